// File: rtl/boruss_io_pkg.sv
// Shared definitions for the Boruss memory-mapped IO blocks: register map,
// status/control bit positions, UART transmitter states and oversampling.
package boruss_io_pkg;

    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_BAUD_DIV = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_BUSY_BIT  = 2;
    localparam int STATUS_OVF_BIT   = 3;

    localparam int CTRL_TX_EN_BIT  = 0;
    localparam int CTRL_PARITY_BIT = 1;

    localparam logic [7:0] BAUD_DIV_RESET = 8'h0F;

    localparam int OVERSAMPLE      = 16;
    localparam int OVERSAMPLE_BITS = $clog2(OVERSAMPLE);
    localparam logic [OVERSAMPLE_BITS-1:0] OVERSAMPLE_LAST = OVERSAMPLE_BITS'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    function automatic logic [7:0] status_byte(input logic full, input logic empty,
                                               input logic busy, input logic ovf);
        status_byte                   = '0;
        status_byte[STATUS_FULL_BIT]  = full;
        status_byte[STATUS_EMPTY_BIT] = empty;
        status_byte[STATUS_BUSY_BIT]  = busy;
        status_byte[STATUS_OVF_BIT]   = ovf;
    endfunction

endpackage

// File: rtl/boruss_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module boruss_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/boruss_uart_tx_mmio.sv
// Memory-mapped UART transmitter: four-register bus window, transmit FIFO and
// a 16x-oversampled frame generator with optional even parity.
module boruss_uart_tx_mmio
    import boruss_io_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'hF0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_address,
    input  logic [7:0] data_in,
    input  logic       data_write_enable,
    input  logic       data_read_enable,
    input  logic       memory_map_select,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    output logic       uart_tx,
    output logic       tx_busy
);
    localparam int CNT_W = 8 + OVERSAMPLE_BITS;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic           w_sel;
    logic           w_wr;
    logic           w_rd;
    logic [1:0]     w_offset;
    logic           w_wr_txdata;
    logic           w_fifo_pop;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [7:0]     w_fifo_data;
    logic [CW-1:0]  w_fifo_count;
    logic [7:0]     w_read_mux;

    logic [7:0]     r_baud_div;
    logic           r_tx_enable;
    logic           r_parity_en;
    logic           r_overflow;
    logic [7:0]     r_data_out;
    logic           r_data_out_valid;

    tx_state_t      r_state, w_state_next;
    logic [7:0]     r_shift, w_shift_next;
    logic [7:0]     r_frame_div, w_frame_div_next;
    logic           r_frame_par_en, w_frame_par_en_next;
    logic           r_parity_bit, w_parity_bit_next;
    logic           r_tx, w_tx_next;
    logic [2:0]     r_bit_idx, w_bit_idx_next;
    logic [CNT_W-1:0] r_clk_cnt, w_clk_cnt_next;
    logic           w_bit_done;
    logic           w_can_start;

    assign w_sel       = memory_map_select && (data_address[7:2] == BASE_ADDR[7:2]);
    assign w_wr        = w_sel && data_write_enable;
    assign w_rd        = w_sel && data_read_enable && !data_write_enable;
    assign w_offset    = data_address[1:0];
    assign w_wr_txdata = w_wr && (w_offset == REG_TXDATA);

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_out_valid;
    assign uart_tx        = r_tx;
    assign tx_busy        = (r_state != TX_IDLE);

    boruss_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_wr_txdata),
        .i_data  (data_in),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // A dropped byte is one written while full with no pop freeing a slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_baud_div  <= BAUD_DIV_RESET;
            r_tx_enable <= 1'b0;
            r_parity_en <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr && w_offset == REG_BAUD_DIV) r_baud_div <= data_in;
            if (w_wr && w_offset == REG_CTRL) begin
                r_tx_enable <= data_in[CTRL_TX_EN_BIT];
                r_parity_en <= data_in[CTRL_PARITY_BIT];
            end
            if (w_wr_txdata && w_fifo_full && !w_fifo_pop)
                r_overflow <= 1'b1;
            else if (w_wr && w_offset == REG_STATUS && data_in[STATUS_OVF_BIT])
                r_overflow <= 1'b0;
        end
    end

    always_comb begin
        w_read_mux = '0;
        case (w_offset)
            REG_STATUS:   w_read_mux = status_byte(w_fifo_full, w_fifo_empty, tx_busy, r_overflow);
            REG_BAUD_DIV: w_read_mux = r_baud_div;
            REG_CTRL: begin
                w_read_mux[CTRL_TX_EN_BIT]  = r_tx_enable;
                w_read_mux[CTRL_PARITY_BIT] = r_parity_en;
            end
            default:      w_read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_out       <= 8'h00;
            r_data_out_valid <= 1'b0;
        end else begin
            if (w_rd) r_data_out <= w_read_mux;
            r_data_out_valid <= w_rd;
        end
    end

    // Bit period is (div+1)*16 clocks, i.e. the counter ends at {div, 4'hF}.
    assign w_bit_done  = (r_clk_cnt == {r_frame_div, OVERSAMPLE_LAST});
    assign w_can_start = r_tx_enable && (w_fifo_count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= TX_IDLE;
            r_shift        <= 8'h00;
            r_frame_div    <= 8'h00;
            r_frame_par_en <= 1'b0;
            r_parity_bit   <= 1'b0;
            r_tx           <= 1'b1;
            r_bit_idx      <= 3'd0;
            r_clk_cnt      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_shift        <= w_shift_next;
            r_frame_div    <= w_frame_div_next;
            r_frame_par_en <= w_frame_par_en_next;
            r_parity_bit   <= w_parity_bit_next;
            r_tx           <= w_tx_next;
            r_bit_idx      <= w_bit_idx_next;
            r_clk_cnt      <= w_clk_cnt_next;
        end
    end

    // The line level for the next state is computed here so uart_tx is a flop.
    always_comb begin
        w_state_next        = r_state;
        w_shift_next        = r_shift;
        w_frame_div_next    = r_frame_div;
        w_frame_par_en_next = r_frame_par_en;
        w_parity_bit_next   = r_parity_bit;
        w_tx_next           = r_tx;
        w_bit_idx_next      = r_bit_idx;
        w_clk_cnt_next      = r_clk_cnt + 1'b1;
        w_fifo_pop          = 1'b0;
        case (r_state)
            TX_IDLE: begin
                w_clk_cnt_next = '0;
                w_tx_next      = 1'b1;
                if (w_can_start) begin
                    w_fifo_pop   = 1'b1;
                    w_state_next = TX_START;
                    w_tx_next    = 1'b0;
                end
            end
            TX_START: begin
                if (w_bit_done) begin
                    w_clk_cnt_next = '0;
                    w_bit_idx_next = 3'd0;
                    w_state_next   = TX_DATA;
                    w_tx_next      = r_shift[0];
                end
            end
            TX_DATA: begin
                if (w_bit_done) begin
                    w_clk_cnt_next = '0;
                    w_shift_next   = r_shift >> 1;
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        if (r_frame_par_en) begin
                            w_state_next = TX_PARITY;
                            w_tx_next    = r_parity_bit;
                        end else begin
                            w_state_next = TX_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_tx_next = r_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (w_bit_done) begin
                    w_clk_cnt_next = '0;
                    w_state_next   = TX_STOP;
                    w_tx_next      = 1'b1;
                end
            end
            TX_STOP: begin
                if (w_bit_done) begin
                    w_clk_cnt_next = '0;
                    if (w_can_start) begin
                        w_fifo_pop   = 1'b1;
                        w_state_next = TX_START;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = TX_IDLE;
                        w_tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = TX_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
        if (w_fifo_pop) begin
            w_shift_next        = w_fifo_data;
            w_frame_div_next    = r_baud_div;
            w_frame_par_en_next = r_parity_en;
            w_parity_bit_next   = ^w_fifo_data;
        end
    end

endmodule

// File: tb/tb_boruss_uart_tx_mmio.sv
// Directed bench for boruss_uart_tx_mmio: register access, framing, parity,
// FIFO overflow with back-to-back frames, baud change and mid-frame reset.
module tb_boruss_uart_tx_mmio;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_address = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       data_write_enable = 1'b0;
    logic       data_read_enable = 1'b0;
    logic       memory_map_select = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       uart_tx;
    logic       tx_busy;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] A_TX   = 8'hF0;
    localparam logic [7:0] A_ST   = 8'hF1;
    localparam logic [7:0] A_BAUD = 8'hF2;
    localparam logic [7:0] A_CTRL = 8'hF3;

    always #5 clk = ~clk;

    boruss_uart_tx_mmio #(
        .BASE_ADDR  (8'hF0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .data_address      (data_address),
        .data_in           (data_in),
        .data_write_enable (data_write_enable),
        .data_read_enable  (data_read_enable),
        .memory_map_select (memory_map_select),
        .data_out          (data_out),
        .data_out_valid    (data_out_valid),
        .uart_tx           (uart_tx),
        .tx_busy           (tx_busy)
    );

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data, input logic sel);
        @(negedge clk);
        data_address      = addr;
        data_in           = data;
        memory_map_select = sel;
        data_write_enable = 1'b1;
        @(posedge clk);
        #1;
        data_write_enable = 1'b0;
        memory_map_select = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, input logic sel,
                            output logic [7:0] d, output logic v, output logic v_next);
        @(negedge clk);
        data_address      = addr;
        memory_map_select = sel;
        data_read_enable  = 1'b1;
        @(posedge clk);
        #1;
        d = data_out;
        v = data_out_valid;
        data_read_enable  = 1'b0;
        memory_map_select = 1'b0;
        @(posedge clk);
        #1;
        v_next = data_out_valid;
    endtask

    // Waits for a start bit, then samples each bit in its middle.
    task automatic capture_frame(input int period, input int nbits, output logic [10:0] bits);
        int waited;
        waited = 0;
        bits   = '0;
        @(posedge clk);
        #1;
        while (uart_tx !== 1'b0 && waited < 5000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (uart_tx !== 1'b0) begin
            $display("[TB] FAIL frame_start: uart_tx=%b after %0d cycles, required 0", uart_tx, waited);
            bad++;
            total++;
            bits = 'x;
            return;
        end
        repeat (period / 2) @(posedge clk);
        #1;
        bits[0] = uart_tx;
        for (int i = 1; i < nbits; i++) begin
            repeat (period) @(posedge clk);
            #1;
            bits[i] = uart_tx;
        end
    endtask

    task automatic count_busy(input int limit, output int n);
        int waited;
        waited = 0;
        n      = 0;
        while (tx_busy !== 1'b1 && waited < 5000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        while (tx_busy === 1'b1 && n < limit) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        $display("[TB] running test_reset");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (uart_tx !== 1'b1) begin $display("[TB] FAIL reset_uart_tx: got %b need 1", uart_tx); bad++; end
        total++;
        if (tx_busy !== 1'b0) begin $display("[TB] FAIL reset_tx_busy: got %b need 0", tx_busy); bad++; end
        total++;
        if (data_out !== 8'h00) begin $display("[TB] FAIL reset_data_out: got %h need 00", data_out); bad++; end
        total++;
        if (data_out_valid !== 1'b0) begin $display("[TB] FAIL reset_valid: got %b need 0", data_out_valid); bad++; end
        total++;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_register_access();
        logic [7:0] d;
        logic v, vn;
        $display("[TB] running test_register_access");
        bus_read(A_BAUD, 1'b1, d, v, vn);
        if (d !== 8'h0F) begin $display("[TB] FAIL baud_reset_read: got %h need 0F", d); bad++; end
        total++;
        if (v !== 1'b1) begin $display("[TB] FAIL baud_read_valid: got %b need 1", v); bad++; end
        total++;
        if (vn !== 1'b0) begin $display("[TB] FAIL valid_one_cycle: got %b need 0", vn); bad++; end
        total++;
        bus_read(A_CTRL, 1'b1, d, v, vn);
        if (d !== 8'h00) begin $display("[TB] FAIL ctrl_reset_read: got %h need 00", d); bad++; end
        total++;
        bus_read(A_ST, 1'b1, d, v, vn);
        if (d !== 8'h02) begin $display("[TB] FAIL status_reset_read: got %h need 02", d); bad++; end
        total++;
        bus_read(A_TX, 1'b1, d, v, vn);
        if (d !== 8'h00 || v !== 1'b1) begin $display("[TB] FAIL txdata_read: got %h/%b need 00/1", d, v); bad++; end
        total++;
        bus_read(A_BAUD, 1'b0, d, v, vn);
        if (v !== 1'b0 || data_out !== 8'h00) begin
            $display("[TB] FAIL unselected_read: valid %b data %h need 0/00", v, data_out); bad++;
        end
        total++;
        bus_read(8'hE2, 1'b1, d, v, vn);
        if (v !== 1'b0) begin $display("[TB] FAIL out_of_window_read: valid %b need 0", v); bad++; end
        total++;
        bus_write(A_CTRL, 8'hFF, 1'b1);
        bus_read(A_CTRL, 1'b1, d, v, vn);
        if (d !== 8'h03) begin $display("[TB] FAIL ctrl_upper_bits: got %h need 03", d); bad++; end
        total++;
        bus_write(A_CTRL, 8'h00, 1'b1);
        @(negedge clk);
        data_address      = A_BAUD;
        data_in           = 8'h22;
        memory_map_select = 1'b1;
        data_write_enable = 1'b1;
        data_read_enable  = 1'b1;
        @(posedge clk);
        #1;
        v = data_out_valid;
        data_write_enable = 1'b0;
        data_read_enable  = 1'b0;
        memory_map_select = 1'b0;
        if (v !== 1'b0) begin $display("[TB] FAIL rw_same_cycle_valid: got %b need 0", v); bad++; end
        total++;
        bus_write(A_BAUD, 8'h55, 1'b0);
        bus_write(8'hE2, 8'h66, 1'b1);
        bus_read(A_BAUD, 1'b1, d, v, vn);
        if (d !== 8'h22) begin $display("[TB] FAIL baud_write_decode: got %h need 22", d); bad++; end
        total++;
    endtask

    task automatic test_basic_frame();
        logic [10:0] bits;
        logic [10:0] exp;
        int n;
        $display("[TB] running test_basic_frame");
        bus_write(A_BAUD, 8'h00, 1'b1);
        bus_write(A_CTRL, 8'h01, 1'b1);
        bus_write(A_TX, 8'hA5, 1'b1);
        fork
            capture_frame(16, 10, bits);
            count_busy(2000, n);
        join
        exp = {1'b0, 1'b1, 8'hA5, 1'b0};
        if (bits !== exp) begin $display("[TB] FAIL frame_a5_bits: got %b need %b", bits, exp); bad++; end
        total++;
        if (n != 160) begin $display("[TB] FAIL frame_a5_busy: got %0d clocks need 160", n); bad++; end
        total++;
    endtask

    task automatic test_parity();
        logic [10:0] bits;
        logic [10:0] exp;
        int n;
        $display("[TB] running test_parity");
        bus_write(A_CTRL, 8'h03, 1'b1);
        bus_write(A_TX, 8'h07, 1'b1);
        fork
            capture_frame(16, 11, bits);
            count_busy(2000, n);
        join
        exp = {1'b1, 1'b1, 8'h07, 1'b0};
        if (bits !== exp) begin $display("[TB] FAIL parity_frame_bits: got %b need %b", bits, exp); bad++; end
        total++;
        if (n != 176) begin $display("[TB] FAIL parity_frame_busy: got %0d clocks need 176", n); bad++; end
        total++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [5];
        logic [7:0] d;
        logic v, vn;
        logic [10:0] fb;
        logic [10:0] exp;
        int n;
        $display("[TB] running test_back_to_back");
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bus_write(A_CTRL, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) bus_write(A_TX, bytes[k], 1'b1);
        bus_read(A_ST, 1'b1, d, v, vn);
        if (d !== 8'h09) begin $display("[TB] FAIL status_full_overflow: got %h need 09", d); bad++; end
        total++;
        bus_write(A_CTRL, 8'h01, 1'b1);
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    capture_frame(16, 10, fb);
                    exp = {1'b0, 1'b1, bytes[k], 1'b0};
                    if (fb !== exp) begin
                        $display("[TB] FAIL b2b_frame%0d: got %b need %b", k, fb, exp); bad++;
                    end
                    total++;
                end
            end
            count_busy(5000, n);
        join
        if (n != 640) begin $display("[TB] FAIL b2b_busy: got %0d clocks need 640", n); bad++; end
        total++;
        bus_read(A_ST, 1'b1, d, v, vn);
        if (d !== 8'h0A) begin $display("[TB] FAIL status_after_drain: got %h need 0A", d); bad++; end
        total++;
        bus_write(A_ST, 8'h08, 1'b1);
        bus_read(A_ST, 1'b1, d, v, vn);
        if (d !== 8'h02) begin $display("[TB] FAIL overflow_clear: got %h need 02", d); bad++; end
        total++;
    endtask

    task automatic test_baud_change();
        logic [10:0] b1;
        logic [10:0] b2;
        logic [10:0] e1;
        logic [10:0] e2;
        $display("[TB] running test_baud_change");
        bus_write(A_BAUD, 8'h00, 1'b1);
        bus_write(A_TX, 8'h0F, 1'b1);
        bus_write(A_TX, 8'h33, 1'b1);
        fork
            begin
                capture_frame(16, 10, b1);
                capture_frame(32, 10, b2);
            end
            begin
                repeat (40) @(posedge clk);
                bus_write(A_BAUD, 8'h01, 1'b1);
            end
        join
        e1 = {1'b0, 1'b1, 8'h0F, 1'b0};
        e2 = {1'b0, 1'b1, 8'h33, 1'b0};
        if (b1 !== e1) begin $display("[TB] FAIL baud_current_frame: got %b need %b", b1, e1); bad++; end
        total++;
        if (b2 !== e2) begin $display("[TB] FAIL baud_next_frame: got %b need %b", b2, e2); bad++; end
        total++;
        repeat (40) @(posedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        logic v, vn;
        $display("[TB] running test_reset_mid_frame");
        bus_write(A_BAUD, 8'h00, 1'b1);
        bus_write(A_TX, 8'hA5, 1'b1);
        bus_write(A_TX, 8'h5A, 1'b1);
        bus_write(A_TX, 8'h3C, 1'b1);
        repeat (68) @(posedge clk);
        #2;
        if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin
            $display("[TB] FAIL in_data_bit3: tx %b busy %b need 0/1", uart_tx, tx_busy); bad++;
        end
        total++;
        reset = 1'b0;
        #1;
        if (uart_tx !== 1'b1) begin $display("[TB] FAIL async_reset_tx: got %b need 1", uart_tx); bad++; end
        total++;
        if (tx_busy !== 1'b0) begin $display("[TB] FAIL async_reset_busy: got %b need 0", tx_busy); bad++; end
        total++;
        @(negedge clk);
        reset = 1'b1;
        bus_read(A_ST, 1'b1, d, v, vn);
        if (d !== 8'h02) begin $display("[TB] FAIL status_after_reset: got %h need 02", d); bad++; end
        total++;
        bus_read(A_BAUD, 1'b1, d, v, vn);
        if (d !== 8'h0F) begin $display("[TB] FAIL baud_after_reset: got %h need 0F", d); bad++; end
        total++;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_register_access();
        test_basic_frame();
        test_parity();
        test_back_to_back();
        test_baud_change();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
